btb_assoc: RTL

BTB_ASSOC -- requirements
Module: btb_assoc

---
 rtl/btb_pkg.sv | 25 ++
 rtl/btb_repl.sv | 24 ++
 rtl/btb_assoc.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// Shared types for the set-associative branch target buffer.
// BTB_COUNTER_EN enables the per-way 2-bit taken counters.
package btb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } btb_state_e;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } btb_ctr_e;

  function automatic btb_ctr_e ctr_update(input btb_ctr_e c, input logic taken);
    logic [1:0] v;
    v = c;
    if (taken) v = (v == 2'b11) ? v : v + 2'd1;
    else       v = (v == 2'b00) ? v : v - 2'd1;
    return btb_ctr_e'(v);
  endfunction

endpackage

// File: rtl/btb_repl.sv
// Victim selection for one BTB set: lowest invalid way first, otherwise the
// set's round-robin pointer. victim_valid flags that a live entry is replaced.
module btb_repl #(
  parameter int NUM_WAYS = 2,
  parameter int WAY_W    = 1
) (
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [WAY_W-1:0]    rr_ptr,
  output logic [WAY_W-1:0]    victim,
  output logic                victim_valid
);

  always_comb begin
    victim       = rr_ptr;
    victim_valid = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim       = WAY_W'(w);
        victim_valid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: combinational lookup on IF_pc,
// update/allocate on ID_pc, one-set-per-cycle flush. Macro: BTB_COUNTER_EN.
//
//   state | meaning
//   IDLE  | lookups and writes serviced
//   FLUSH | clearing set flush_idx_q each cycle, busy high, writes dropped
module btb_assoc
  import btb_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] IF_pc,
  input  logic [PC_WIDTH-1:0] ID_pc,
  input  logic                write,
  input  logic                ID_Branch,
  input  logic                ID_Jump,
  input  logic                ID_taken,
  input  logic [PC_WIDTH-1:0] pc_imm_in,
  input  logic                flush,
  output logic                hit,
  output logic                IF_Branch,
  output logic                IF_Jump,
  output logic                IF_taken,
  output logic [PC_WIDTH-1:0] pc_imm_out,
  output logic                busy
);

  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int TAG_W = PC_WIDTH - 2 - SET_W;

  btb_state_e          state_q;
  logic [SET_W-1:0]    flush_idx_q;
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  logic [WAY_W-1:0]    rr_q     [NUM_SETS];
  logic [TAG_W-1:0]    tag_q    [NUM_SETS][NUM_WAYS];
  logic [PC_WIDTH-1:0] target_q [NUM_SETS][NUM_WAYS];
  logic                br_q     [NUM_SETS][NUM_WAYS];
  logic                jmp_q    [NUM_SETS][NUM_WAYS];

  logic [SET_W-1:0] if_set, id_set;
  logic [TAG_W-1:0] if_tag, id_tag;
  logic             if_hit, id_hit;
  logic [WAY_W-1:0] if_way, id_way;
  logic [WAY_W-1:0] victim, wr_way, rr_cur, rr_next;
  logic             victim_valid;
  logic             do_write;

  assign if_set = IF_pc[2 +: SET_W];
  assign if_tag = IF_pc[PC_WIDTH-1 -: TAG_W];
  assign id_set = ID_pc[2 +: SET_W];
  assign id_tag = ID_pc[PC_WIDTH-1 -: TAG_W];

  // Lowest matching way wins on both ports.
  always_comb begin
    if_hit = 1'b0;
    if_way = '0;
    id_hit = 1'b0;
    id_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[if_set][w] && tag_q[if_set][w] == if_tag) begin
        if_hit = 1'b1;
        if_way = WAY_W'(w);
      end
      if (valid_q[id_set][w] && tag_q[id_set][w] == id_tag) begin
        id_hit = 1'b1;
        id_way = WAY_W'(w);
      end
    end
  end

  btb_repl #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_repl (
    .valid        (valid_q[id_set]),
    .rr_ptr       (rr_q[id_set]),
    .victim       (victim),
    .victim_valid (victim_valid)
  );

  assign busy     = (state_q == FLUSH);
  assign do_write = write && !busy;
  assign wr_way   = id_hit ? id_way : victim;
  assign rr_cur   = rr_q[id_set];
  assign rr_next  = (rr_cur == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_cur + WAY_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            state_q     <= FLUSH;
            flush_idx_q <= '0;
          end
        end
        FLUSH: begin
          valid_q[flush_idx_q] <= '0;
          flush_idx_q          <= flush_idx_q + SET_W'(1);
          if (flush_idx_q == SET_W'(NUM_SETS - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (do_write) begin
        valid_q[id_set][wr_way] <= 1'b1;
        if (!id_hit && victim_valid) rr_q[id_set] <= rr_next;
      end
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      tag_q[id_set][wr_way]    <= id_tag;
      target_q[id_set][wr_way] <= pc_imm_in;
      br_q[id_set][wr_way]     <= ID_Branch;
      jmp_q[id_set][wr_way]    <= ID_Jump;
    end
  end

  assign hit        = if_hit && !busy;
  assign pc_imm_out = hit ? target_q[if_set][if_way] : '0;
  assign IF_Branch  = hit && br_q[if_set][if_way];
  assign IF_Jump    = hit && jmp_q[if_set][if_way];

`ifdef BTB_COUNTER_EN
  btb_ctr_e   ctr_q [NUM_SETS][NUM_WAYS];
  logic [1:0] ctr_if;

  always_ff @(posedge clk) begin
    if (do_write) begin
      if (ID_Jump)     ctr_q[id_set][wr_way] <= CTR_ST;
      else if (id_hit) ctr_q[id_set][wr_way] <= ctr_update(ctr_q[id_set][wr_way], ID_taken);
      else             ctr_q[id_set][wr_way] <= ID_taken ? CTR_WT : CTR_WNT;
    end
  end

  assign ctr_if   = ctr_q[if_set][if_way];
  assign IF_taken = hit && ctr_if[1];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{IF_pc[1:0], ID_pc[1:0]};
`else
  assign IF_taken = hit;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{IF_pc[1:0], ID_pc[1:0], ID_taken};
`endif

endmodule
